// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller.
// Holds the FSM state encoding, default geometry and the idle levels of the SPI pins.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } spi_state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic IDLE_CS   = 1'b1;
    localparam logic IDLE_SCLK = 1'b0;
    localparam logic IDLE_MOSI = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// One synchronizer chain for an asynchronous SPI pin, with rise/fall detection in the clk domain.
// The chain and the edge-detect flop both reset to the pin's idle level, so reset never fakes an edge.
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave (MSB first), oversampled by clk, with a single-word receive holding register.
// Define SPI_OVERRUN_EN to build the sticky overrun detector; otherwise overrun is tied low.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 2);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(IDLE_SCLK)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(IDLE_CS)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(IDLE_MOSI)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_s, mosi_rise, mosi_fall};

    spi_state_t       state, state_nx;
    logic [WIDTH-1:0] rx_sr, tx_sr, rx_shift;
    logic [CW-1:0]    bit_cnt;
    logic [SW-1:0]    settle_cnt;
    logic             settling, last_bit, err_done;
    logic             load_tx, start, do_rx, do_tx, word_done, err_now, err_arm;

    // A cs fall seen while the synchronizers are still settling after reset is a frame
    // already in progress, not a new one.
    assign settling = (settle_cnt != '0);
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));
    assign rx_shift = {rx_sr[WIDTH-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = settling ? WAIT_CS : SHIFT;
            SHIFT: begin
                // The sclk edge is handled before a coincident cs rise.
                if (sclk_rise && last_bit) state_nx = cs_rise ? IDLE : WAIT_CS;
                else if (cs_rise)          state_nx = IDLE;
            end
            WAIT_CS: if (cs_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        load_tx   = 1'b0;
        start     = 1'b0;
        do_rx     = 1'b0;
        do_tx     = 1'b0;
        word_done = 1'b0;
        err_now   = 1'b0;
        err_arm   = 1'b0;
        case (state)
            IDLE: begin
                err_arm = 1'b1;
                start   = cs_fall && !settling;
                load_tx = cs_fall && !settling;
            end
            SHIFT: begin
                do_rx     = sclk_rise;
                do_tx     = sclk_fall;
                word_done = sclk_rise && last_bit;
                err_now   = cs_rise && !(sclk_rise && last_bit);
            end
            WAIT_CS: err_now = sclk_rise && !err_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr      <= '0;
            tx_sr      <= '0;
            bit_cnt    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            err_done   <= 1'b0;
            settle_cnt <= SW'(SYNC_STAGES + 1);
        end else begin
            frame_err <= err_now;
            if (settling) settle_cnt <= settle_cnt - SW'(1);

            if (load_tx)    tx_sr <= tx_data;
            else if (do_tx) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};

            if (start) begin
                rx_sr   <= '0;
                bit_cnt <= '0;
            end else if (do_rx) begin
                rx_sr   <= rx_shift;
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (word_done) rx_data <= rx_shift;
            // A completing word beats a simultaneous acknowledge.
            if (word_done)   rx_valid <= 1'b1;
            else if (rx_ack) rx_valid <= 1'b0;

            // Entering WAIT_CS from a settling reset mutes the over-long-frame error.
            if (err_arm)      err_done <= settling;
            else if (err_now) err_done <= 1'b1;
        end
    end

    assign miso = !cs_s && tx_sr[WIDTH-1];

`ifdef SPI_OVERRUN_EN
    logic overrun_r;
    always_ff @(posedge clk) begin
        if (rst)                                      overrun_r <= 1'b0;
        else if (word_done && rx_valid && !rx_ack)    overrun_r <= 1'b1;
    end
    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: an SPI master driver plus a frame-level model of what the slave must report.
// Build with SPI_OVERRUN_EN defined to exercise the overrun flag.
module tb_spi_slave_ctrl;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int HP = 6;

    logic         clk = 1'b0;
    logic         rst, sclk, cs, mosi, miso;
    logic         rx_valid, rx_ack, busy, frame_err, overrun;
    logic [W-1:0] tx_data, rx_data;

    int           n_cmp = 0;
    int           n_err = 0;
    int           total_fe = 0;
    bit           check_en = 1'b0;
    bit           model_valid = 1'b0;
    bit           model_ovr = 1'b0;
    logic [W-1:0] exp_q[$];

    spi_slave_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_rx();
        if (exp_q.size() == 0) return '0;
        return exp_q[exp_q.size()-1];
    endfunction

    // scoreboard: between frames the outputs must match the model every cycle
    always @(negedge clk) begin
        if (frame_err === 1'b1) total_fe++;
        if (check_en) begin
            chk("rx_data", rx_data, exp_rx());
            chk("rx_valid", rx_valid, model_valid);
            chk("overrun", overrun, model_ovr);
            chk("busy_idle", busy, 0);
            chk("frame_err_idle", frame_err, 0);
            chk("miso_idle", miso, 0);
        end
    end

    // driver: one SPI bit, mosi set on the preceding fall, miso sampled at the rise
    task automatic clock_bit(input logic b, input bit race, input bit cs_with_rise, output logic s);
        mosi = b;
        tick(HP);
        sclk = 1'b1;
        s = miso;
        if (cs_with_rise) cs = 1'b1;
        if (race) begin
            tick(S);
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
            tick(HP - S - 1);
        end else begin
            tick(HP);
        end
        sclk = 1'b0;
    endtask

    task automatic do_frame(input logic [W-1:0] mword, input logic [W-1:0] sword, input int nbits,
                            input bit race, input bit cs_last, output logic [W-1:0] got);
        int           fe0;
        logic         s;
        logic [W-1:0] mask;
        got = '0;
        check_en = 1'b0;
        fe0 = total_fe;
        tx_data = sword;
        cs = 1'b0;
        tick(6);
        tx_data = W'($urandom);
        for (int i = 0; i < nbits; i++) begin
            clock_bit((i < W) ? mword[W-1-i] : 1'($urandom_range(0, 1)),
                      race && (i == W - 1), cs_last && (i == nbits - 1), s);
            if (i < W) got[W-1-i] = s;
        end
        if (!cs_last) begin
            tick(HP);
            if (nbits > W) chk("busy_wait_cs", busy, 1);
            cs = 1'b1;
        end
        mosi = 1'b0;
        tick(10);
        chk("frame_err_pulses", total_fe - fe0, (nbits == W) ? 0 : 1);
        mask = (nbits >= W) ? '1 : ~((W'(1) << (W - nbits)) - W'(1));
        chk("miso_bits", got & mask, sword & mask);
        if (nbits >= W) begin
`ifdef SPI_OVERRUN_EN
            if (model_valid && !race) model_ovr = 1'b1;
`endif
            exp_q.push_back(mword);
            model_valid = 1'b1;
        end
        check_en = 1'b1;
        tick(2);
    endtask

    task automatic ack();
        check_en = 1'b0;
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        model_valid = 1'b0;
        tick(1);
        check_en = 1'b1;
    endtask

    task automatic reset_mid_frame();
        logic s;
        int   fe0;
        check_en = 1'b0;
        tx_data = W'($urandom);
        cs = 1'b0;
        tick(6);
        for (int i = 0; i < 7; i++) clock_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, s);
        mosi = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        model_valid = 1'b0;
        model_ovr = 1'b0;
        fe0 = total_fe;
        for (int i = 7; i < W; i++) clock_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, s);
        tick(HP);
        cs = 1'b1;
        mosi = 1'b0;
        tick(10);
        chk("rst_tail_frame_err", total_fe - fe0, 0);
        check_en = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [W-1:0] got, mw;
        int           nb;
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rx_ack = 1'b0; tx_data = '0;
        tick(4);
        chk("init_rx_data", rx_data, 0);
        chk("init_rx_valid", rx_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_miso", miso, 0);
        chk("init_frame_err", frame_err, 0);
        chk("init_overrun", overrun, 0);
        rst = 1'b0;
        tick(6);
        check_en = 1'b1;

        do_frame(16'h1234, 16'h5AF0, W, 1'b0, 1'b0, got);
        chk("pin_rx_1234", rx_data, 16'h1234);
        chk("pin_miso_5af0", got, 16'h5AF0);
        ack();

        do_frame(W'($urandom), W'($urandom), 9, 1'b0, 1'b0, got);
        chk("pin_short_valid", rx_valid, 0);

        do_frame(16'hC3A5, W'($urandom), 17, 1'b0, 1'b0, got);
        chk("pin_long_rx", rx_data, 16'hC3A5);
        ack();

        do_frame(16'hAAAA, W'($urandom), W, 1'b0, 1'b0, got);
        do_frame(16'h5555, W'($urandom), W, 1'b0, 1'b0, got);
        chk("pin_ovr_rx", rx_data, 16'h5555);
`ifdef SPI_OVERRUN_EN
        chk("pin_ovr_flag", overrun, 1);
`else
        chk("pin_ovr_flag", overrun, 0);
`endif

        do_frame(16'h0F1E, W'($urandom), W, 1'b1, 1'b0, got);
        chk("pin_race_valid", rx_valid, 1);
        chk("pin_race_rx", rx_data, 16'h0F1E);

        do_frame(W'($urandom), W'($urandom), W, 1'b0, 1'b1, got);
        do_frame(W'($urandom), W'($urandom), 5, 1'b0, 1'b1, got);

        for (int k = 0; k < 24; k++) begin
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W + 3) : W;
            mw = W'($urandom);
            do_frame(mw, W'($urandom), nb, 1'b0, 1'b0, got);
            if ($urandom_range(0, 1) == 1) ack();
        end

        reset_mid_frame();

        for (int k = 0; k < 4; k++) begin
            do_frame(W'($urandom), W'($urandom), W, 1'b0, 1'b0, got);
            if ($urandom_range(0, 1) == 1) ack();
        end

        check_en = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
